// File: rtl/ias_pkg.sv
// Shared definitions for the IAS-style 8-bit core: opcodes, controller states,
// decoder instruction classes and default widths.
package ias_pkg;

  localparam int IAS_ADDR_W = 5;
  localparam int IAS_DATA_W = 8;
  localparam int OPCODE_W   = 3;

  localparam logic [OPCODE_W-1:0] OP_LOAD  = 3'b000;
  localparam logic [OPCODE_W-1:0] OP_ADD   = 3'b001;
  localparam logic [OPCODE_W-1:0] OP_STOR  = 3'b010;
  localparam logic [OPCODE_W-1:0] OP_JUMP  = 3'b011;
  localparam logic [OPCODE_W-1:0] OP_JUMPZ = 3'b100;
  localparam logic [OPCODE_W-1:0] OP_HALT  = 3'b111;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC_RD,
    EXEC_WR,
    HALT
  } state_e;

  // What DECODE does next; CLS_NEXT covers jumps and NOPs (back to FETCH).
  typedef enum logic [1:0] {
    CLS_READ,
    CLS_WRITE,
    CLS_NEXT,
    CLS_STOP
  } op_class_e;

endpackage

// File: rtl/ias_control_unit_if.sv
// Single-port memory bus between the control unit (master) and the shared memory (slave).
interface ias_control_unit_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/ias_decoder.sv
// Combinational instruction decoder. Conditional jump on opcode 100 is built only
// when IAS_CU_JUMPZ_EN is defined; otherwise that opcode is a NOP.
module ias_decoder
  import ias_pkg::*;
#(
  parameter int ADDR_W = IAS_ADDR_W,
  parameter int DATA_W = IAS_DATA_W
) (
  input  logic [DATA_W-1:0] ir,
`ifdef IAS_CU_JUMPZ_EN
  input  logic [DATA_W-1:0] ac_data,
`endif
  output op_class_e         op_class,
  output logic              jump_taken,
  output logic              rd_add,
  output logic [ADDR_W-1:0] target
);

  logic [OPCODE_W-1:0] opcode;

  assign opcode = ir[DATA_W-1 -: OPCODE_W];
  assign target = ir[ADDR_W-1:0];

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    op_class   = CLS_NEXT;
    jump_taken = 1'b0;
    rd_add     = (opcode == OP_ADD);
    case (opcode)
      OP_LOAD,
      OP_ADD:   op_class = CLS_READ;
      OP_STOR:  op_class = CLS_WRITE;
      OP_JUMP:  jump_taken = 1'b1;
`ifdef IAS_CU_JUMPZ_EN
      OP_JUMPZ: jump_taken = (ac_data == '0);
`endif
      OP_HALT:  op_class = CLS_STOP;
      default:  op_class = CLS_NEXT;
    endcase
  end

endmodule

// File: rtl/ias_control_unit.sv
// Fetch/decode/execute sequencer for the IAS-style core; sole master of the memory bus.
// Optional feature macro: IAS_CU_JUMPZ_EN (conditional jump on opcode 100).
module ias_control_unit
  import ias_pkg::*;
#(
  parameter int ADDR_W = IAS_ADDR_W,
  parameter int DATA_W = IAS_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  ias_control_unit_if.master  bus,
  input  logic [DATA_W-1:0]   ac_data,
  output logic                load_ac,
  output logic                add_enable,
  output logic [ADDR_W-1:0]   pc,
  output logic [DATA_W-1:0]   ir,
  output logic                halted
);

  state_e            state, state_d;
  logic [ADDR_W-1:0] pc_d;
  logic [DATA_W-1:0] ir_d;
  logic              halted_d;
  logic              req, load, add;

  op_class_e         op_class;
  logic              jump_taken;
  logic              rd_add;
  logic [ADDR_W-1:0] target;

  ias_decoder #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_decoder (
    .ir         (ir),
`ifdef IAS_CU_JUMPZ_EN
    .ac_data    (ac_data),
`endif
    .op_class   (op_class),
    .jump_taken (jump_taken),
    .rd_add     (rd_add),
    .target     (target)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= FETCH;
      pc     <= '0;
      ir     <= '0;
      halted <= 1'b0;
    end else begin
      state  <= state_d;
      pc     <= pc_d;
      ir     <= ir_d;
      halted <= halted_d;
    end
  end

  always_comb begin
    state_d      = state;
    pc_d         = pc;
    ir_d         = ir;
    halted_d     = halted;
    req          = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_addr = pc;
    load         = 1'b0;
    add          = 1'b0;
    case (state)
      FETCH: begin
        req = 1'b1;
        if (bus.mem_ack) begin
          ir_d    = bus.mem_rdata;
          pc_d    = pc + ADDR_W'(1);
          state_d = DECODE;
        end
      end
      DECODE: begin
        case (op_class)
          CLS_READ:  state_d = EXEC_RD;
          CLS_WRITE: state_d = EXEC_WR;
          CLS_STOP: begin
            halted_d = 1'b1;
            state_d  = HALT;
          end
          default: begin
            if (jump_taken) pc_d = target;
            state_d = FETCH;
          end
        endcase
      end
      EXEC_RD: begin
        req          = 1'b1;
        bus.mem_addr = target;
        if (bus.mem_ack) begin
          load    = !rd_add;
          add     = rd_add;
          state_d = FETCH;
        end
      end
      EXEC_WR: begin
        req          = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = target;
        if (bus.mem_ack) state_d = FETCH;
      end
      default: state_d = HALT;
    endcase
  end

  // Reset masks the bus request and strobes at once, so an aborted transfer
  // cannot update the AC even if its ack arrives while reset is still high.
  assign bus.mem_req   = req  && !reset;
  assign load_ac       = load && !reset;
  assign add_enable    = add  && !reset;
  assign bus.mem_wdata = ac_data;

endmodule
